wta_select: RTL and testbench
=============================

WTA_SELECT -- requirements
Module: wta_select

Interface
REQ-001 Parameter min_disparity, default 20: disparity offset added to the winning index.
REQ-002 Parameter max_disparity, default 128: upper disparity bound, also the border width for WTA_INVALID_BORDER_EN.
REQ-003 Parameter disp_range, default 108: number of 8-bit costs per pixel.
REQ-004 Parameter frame_width, default 400; parameter frame_height, default 200.
REQ-005 Parameter pixel_width, default 8: cost lane width.
REQ-006 clk  input  1  single clock; all state changes on posedge clk.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 cost_aggr  input  864  aggregated costs; lane d at bits [8d+7:8d], d = 0..107.
REQ-009 in_valid  input  1  cost_aggr, in_row and in_col are meaningful this cycle.
REQ-010 in_row, in_col  input  10 each  pixel coordinates of cost_aggr.
REQ-011 disparity  output  8  min_disparity plus index of the minimum-cost lane.
REQ-012 min_cost  output  8  minimum cost value; also feeds the aggregate stage as min_aggr_last.
REQ-013 out_row, out_col  output  10 each  coordinates aligned with disparity.
REQ-014 valid  output  1  disparity, min_cost, out_row and out_col are meaningful.
REQ-015 frame_done  output  1  one-cycle pulse on the last pixel of a frame.

Function
REQ-016 Fully pipelined, no stalls; accepts one pixel per cycle and has no backpressure.
REQ-017 Stage 0 registers cost_aggr, in_valid, in_row and in_col.
REQ-018 Stage 0 is followed by 7 pairwise-min reduction levels, 108->54->27->14->7->4->2->1.
REQ-019 At an odd-count level, the last (value, index) pair passes through unchanged.
REQ-020 Compare is unsigned 8-bit.
REQ-021 Tie-break: on equal cost the lower index wins, so the first minimum is selected.
REQ-022 Each reduction entry carries an 8-bit value and a 7-bit index.
REQ-023 disparity = min_disparity + index, computed in 8 bits; no overflow for the default parameters (max 127).
REQ-024 Latency: input sampled at edge N appears on the outputs after edge N+8.
REQ-025 valid, out_row and out_col are delayed by the same 8 stages as the data.
REQ-026 Pipeline registers update every cycle regardless of in_valid; invalid slots carry don't-care data with valid=0.
REQ-027 frame_done=1 for exactly the output cycle where valid=1, out_row=frame_height-1 and out_col=frame_width-1.
REQ-028 frame_done=0 on all other cycles.
REQ-029 frame_done is combinationally independent of the inputs and is registered.
REQ-030 All-255 input -> min_cost=255, disparity=min_disparity.

Reset
REQ-031 While rst=1, all pipeline registers clear asynchronously.
REQ-032 Reset values: disparity=0, min_cost=8'hFF, out_row=0, out_col=0, valid=0, frame_done=0.
REQ-033 Reset asserted mid-stream discards every in-flight pixel; no valid output is produced for any pixel sampled before reset release.
REQ-034 The first input sampled at the first edge after rst falls appears 8 cycles later.

Configuration
REQ-035 Macro WTA_INVALID_BORDER_EN.
REQ-036 When defined: output pixels with out_col < max_disparity have disparity forced to 0; min_cost is still the true minimum.
REQ-037 When defined: the border decision is made on the delayed column, so latency is unchanged.
REQ-038 When undefined: disparity is always min_disparity + index, and no border logic is synthesized.

Verification
REQ-039 Lane 37 = 3, all other lanes = 200, in_valid=1, col=150 -> 8 cycles later valid=1, disparity=57, min_cost=3.
REQ-040 Lanes 10 and 90 = 5, others = 9 -> disparity=30 (lower index wins), min_cost=5.
REQ-041 Lane 107 = 0, others = 1 (odd pass-through path) -> disparity=127, min_cost=0.
REQ-042 Lane 107 = 0, others = 1, at a column below the border:
  - with WTA_INVALID_BORDER_EN, col=50 -> disparity=0, min_cost=0;
  - without the macro, col=50 -> disparity=127.
REQ-043 Stream 400x200 back-to-back pixels, in_valid=1 every cycle -> valid stays high continuously and frame_done pulses once, with out_row=199, out_col=399.
REQ-044 Assert rst for 1 cycle 4 cycles after injecting a pixel -> outputs return to reset values immediately and that pixel never appears with valid=1.

Source files
------------

// File: rtl/wta_select.sv
// rtl/wta_select.sv - winner-take-all disparity selection: 8-stage pairwise-min tree over per-pixel costs
// Optional feature macro: WTA_INVALID_BORDER_EN (forces disparity to 0 for columns below max_disparity).
module wta_select #(
    parameter int min_disparity = 20,
    parameter int max_disparity = 128,
    parameter int disp_range    = 108,
    parameter int frame_width   = 400,
    parameter int frame_height  = 200,
    parameter int pixel_width   = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [pixel_width*disp_range-1:0] cost_aggr,
    input  logic                              in_valid,
    input  logic [9:0]                        in_row,
    input  logic [9:0]                        in_col,
    output logic [7:0]                        disparity,
    output logic [pixel_width-1:0]            min_cost,
    output logic [9:0]                        out_row,
    output logic [9:0]                        out_col,
    output logic                              valid,
    output logic                              frame_done
);

    localparam int LEVELS = $clog2(disp_range);
    localparam int IW     = $clog2(disp_range);
    localparam int HALF   = (disp_range + 1) / 2;

    if (min_disparity + disp_range > 256 || max_disparity > 1024) begin : g_bad_params
        $error("wta_select: disparity range does not fit the output widths");
    end

    // Level 0 is the input register; level l holds the result of the l-th min reduction.
    logic [pixel_width-1:0] val_d [LEVELS+1][disp_range];
    logic [pixel_width-1:0] val_q [LEVELS+1][disp_range];
    logic [IW-1:0]          idx_d [LEVELS+1][disp_range];
    logic [IW-1:0]          idx_q [LEVELS+1][disp_range];
    logic                   valid_d [LEVELS+1];
    logic                   valid_q [LEVELS+1];
    logic [9:0]             row_d [LEVELS+1];
    logic [9:0]             row_q [LEVELS+1];
    logic [9:0]             col_d [LEVELS+1];
    logic [9:0]             col_q [LEVELS+1];

    logic [7:0]             disparity_d, disparity_q;
    logic [pixel_width-1:0] min_cost_d, min_cost_q;
    logic [9:0]             out_row_d, out_row_q;
    logic [9:0]             out_col_d, out_col_q;
    logic                   valid_out_d, valid_out_q;
    logic                   frame_done_d, frame_done_q;

    // Strict less-than keeps the left (lower-index) entry on ties, so the first minimum wins.
    always_comb begin
        int n_in;
        int b;
        n_in = disp_range;
        b    = 0;
        for (int i = 0; i < disp_range; i++) begin
            val_d[0][i] = cost_aggr[i*pixel_width +: pixel_width];
            idx_d[0][i] = IW'(i);
        end
        for (int l = 1; l <= LEVELS; l++) begin
            for (int i = 0; i < disp_range; i++) begin
                val_d[l][i] = '1;
                idx_d[l][i] = '0;
            end
            for (int i = 0; i < HALF; i++) begin
                b = (2*i + 1 < disp_range) ? 2*i + 1 : 2*i;
                if (2*i + 1 < n_in) begin
                    if (val_q[l-1][b] < val_q[l-1][2*i]) begin
                        val_d[l][i] = val_q[l-1][b];
                        idx_d[l][i] = idx_q[l-1][b];
                    end else begin
                        val_d[l][i] = val_q[l-1][2*i];
                        idx_d[l][i] = idx_q[l-1][2*i];
                    end
                end else if (2*i < n_in) begin
                    val_d[l][i] = val_q[l-1][2*i];
                    idx_d[l][i] = idx_q[l-1][2*i];
                end
            end
            n_in = (n_in + 1) / 2;
        end
    end

    always_comb begin
        valid_d[0] = in_valid;
        row_d[0]   = in_row;
        col_d[0]   = in_col;
        for (int l = 1; l <= LEVELS; l++) begin
            valid_d[l] = valid_q[l-1];
            row_d[l]   = row_q[l-1];
            col_d[l]   = col_q[l-1];
        end
    end

    always_comb begin
        disparity_d  = 8'(min_disparity) + 8'(idx_q[LEVELS][0]);
`ifdef WTA_INVALID_BORDER_EN
        if (int'(col_q[LEVELS]) < max_disparity) begin
            disparity_d = '0;
        end
`endif
        min_cost_d   = val_q[LEVELS][0];
        out_row_d    = row_q[LEVELS];
        out_col_d    = col_q[LEVELS];
        valid_out_d  = valid_q[LEVELS];
        frame_done_d = valid_q[LEVELS]
                       && (row_q[LEVELS] == 10'(frame_height - 1))
                       && (col_q[LEVELS] == 10'(frame_width - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l <= LEVELS; l++) begin
                for (int i = 0; i < disp_range; i++) begin
                    val_q[l][i] <= '1;
                    idx_q[l][i] <= '0;
                end
                valid_q[l] <= 1'b0;
                row_q[l]   <= '0;
                col_q[l]   <= '0;
            end
            disparity_q  <= '0;
            min_cost_q   <= '1;
            out_row_q    <= '0;
            out_col_q    <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            for (int l = 0; l <= LEVELS; l++) begin
                for (int i = 0; i < disp_range; i++) begin
                    val_q[l][i] <= val_d[l][i];
                    idx_q[l][i] <= idx_d[l][i];
                end
                valid_q[l] <= valid_d[l];
                row_q[l]   <= row_d[l];
                col_q[l]   <= col_d[l];
            end
            disparity_q  <= disparity_d;
            min_cost_q   <= min_cost_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign disparity  = disparity_q;
    assign min_cost   = min_cost_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign valid      = valid_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_wta_select.sv
// tb/tb_wta_select.sv - self-checking bench for wta_select against a first-minimum reference model
module tb_wta_select;

    localparam int MIN_D = 20;
    localparam int MAX_D = 128;
    localparam int DR    = 108;
    localparam int W     = 400;
    localparam int H     = 200;

    logic            clk = 1'b0;
    logic            rst;
    logic [DR*8-1:0] cost_aggr;
    logic            in_valid;
    logic [9:0]      in_row;
    logic [9:0]      in_col;
    logic [7:0]      disparity;
    logic [7:0]      min_cost;
    logic [9:0]      out_row;
    logic [9:0]      out_col;
    logic            valid;
    logic            frame_done;

    always #5 clk = ~clk;

    wta_select dut (
        .clk        (clk),
        .rst        (rst),
        .cost_aggr  (cost_aggr),
        .in_valid   (in_valid),
        .in_row     (in_row),
        .in_col     (in_col),
        .disparity  (disparity),
        .min_cost   (min_cost),
        .out_row    (out_row),
        .out_col    (out_col),
        .valid      (valid),
        .frame_done (frame_done)
    );

    typedef struct {
        bit       v;
        bit [7:0] disp;
        bit [7:0] mc;
        bit [9:0] row;
        bit [9:0] col;
        bit       fd;
    } exp_t;

    int   lanes [DR];
    exp_t pipe_q [$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t model(input bit v, input bit [9:0] r, input bit [9:0] c);
        exp_t e;
        int   best;
        best = 0;
        for (int d = 1; d < DR; d++) if (lanes[d] < lanes[best]) best = d;
        e.v    = v;
        e.mc   = 8'(lanes[best]);
        e.disp = 8'(MIN_D + best);
`ifdef WTA_INVALID_BORDER_EN
        if (int'(c) < MAX_D) e.disp = 8'd0;
`endif
        e.row  = r;
        e.col  = c;
        e.fd   = v && (int'(r) == H - 1) && (int'(c) == W - 1);
        return e;
    endfunction

    task automatic set_pixel(input bit v, input int r, input int c);
        in_valid = v;
        in_row   = 10'(r);
        in_col   = 10'(c);
        for (int d = 0; d < DR; d++) cost_aggr[d*8 +: 8] = 8'(lanes[d]);
    endtask

    task automatic random_lanes();
        int mode;
        mode = $urandom_range(0, 2);
        for (int d = 0; d < DR; d++) begin
            case (mode)
                0:       lanes[d] = $urandom_range(0, 255);
                1:       lanes[d] = $urandom_range(0, 3);
                default: lanes[d] = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 254) : 255;
            endcase
        end
    endtask

    task automatic clear_model();
        exp_t idle;
        idle = '{v: 1'b0, disp: 8'd0, mc: 8'd0, row: 10'd0, col: 10'd0, fd: 1'b0};
        pipe_q.delete();
        repeat (8) pipe_q.push_back(idle);
    endtask

    task automatic step(output exp_t e);
        @(posedge clk);
        pipe_q.push_back(model(in_valid, in_row, in_col));
        #1;
        e = pipe_q.pop_front();
    endtask

    task automatic test_reset();
        for (int d = 0; d < DR; d++) lanes[d] = 0;
        rst = 1'b1;
        set_pixel(1'b1, H - 1, W - 1);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (disparity !== 8'd0)   begin errors++; $display("FAIL reset_disparity: got %0d want 0", disparity); end
        checks++; if (min_cost !== 8'hFF)   begin errors++; $display("FAIL reset_min_cost: got %0h want ff", min_cost); end
        checks++; if (out_row !== 10'd0)    begin errors++; $display("FAIL reset_out_row: got %0d want 0", out_row); end
        checks++; if (out_col !== 10'd0)    begin errors++; $display("FAIL reset_out_col: got %0d want 0", out_col); end
        checks++; if (valid !== 1'b0)       begin errors++; $display("FAIL reset_valid: got %0b want 0", valid); end
        checks++; if (frame_done !== 1'b0)  begin errors++; $display("FAIL reset_frame_done: got %0b want 0", frame_done); end
        rst = 1'b0;
        set_pixel(1'b0, 0, 0);
        clear_model();
    endtask

    task automatic test_directed();
        int   exp_disp [6];
        int   exp_mc   [6];
        int   col      [6];
        exp_t e;
        exp_disp = '{57, 30, 127, 127, 20, 20};
        exp_mc   = '{3, 5, 0, 0, 255, 0};
        col      = '{150, 200, 300, 50, 200, 399};
`ifdef WTA_INVALID_BORDER_EN
        exp_disp[3] = 0;
`endif
        for (int t = 0; t < 6; t++) begin
            for (int d = 0; d < DR; d++) begin
                case (t)
                    0:       lanes[d] = (d == 37) ? 3 : 200;
                    1:       lanes[d] = (d == 10 || d == 90) ? 5 : 9;
                    2, 3:    lanes[d] = (d == 107) ? 0 : 1;
                    4:       lanes[d] = 255;
                    default: lanes[d] = 0;
                endcase
            end
            // Case 5 lands on the last frame pixel but with in_valid low: no frame_done allowed.
            set_pixel(t != 5, (t == 5) ? H - 1 : 7, col[t]);
            for (int k = 0; k <= 8; k++) begin
                step(e);
                if (k == 0) begin
                    random_lanes();
                    set_pixel(1'b0, $urandom_range(0, H - 1), $urandom_range(0, W - 1));
                end
                checks++;
                if ({valid, frame_done} !== {e.v, e.fd}) begin
                    errors++;
                    $display("FAIL directed%0d_ctrl: got valid=%0b fd=%0b want valid=%0b fd=%0b", t, valid, frame_done, e.v, e.fd);
                end
                if (k == 8 && t != 5) begin
                    checks++;
                    if ({valid, disparity, min_cost, out_col} !== {1'b1, 8'(exp_disp[t]), 8'(exp_mc[t]), 10'(col[t])}) begin
                        errors++;
                        $display("FAIL directed%0d_data: got valid=%0b disp=%0d cost=%0d col=%0d want valid=1 disp=%0d cost=%0d col=%0d",
                                 t, valid, disparity, min_cost, out_col, exp_disp[t], exp_mc[t], col[t]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        for (int k = 0; k < 400; k++) begin
            random_lanes();
            if ($urandom_range(0, 9) == 0) set_pixel($urandom_range(0, 1), H - 1, W - 1);
            else set_pixel($urandom_range(0, 3) != 0, $urandom_range(0, H - 1), $urandom_range(0, W - 1));
            step(e);
            checks++;
            if ({valid, frame_done} !== {e.v, e.fd}) begin
                errors++;
                $display("FAIL random_ctrl@%0d: got valid=%0b fd=%0b want valid=%0b fd=%0b", k, valid, frame_done, e.v, e.fd);
            end
            if (e.v) begin
                checks++;
                if ({disparity, min_cost, out_row, out_col} !== {e.disp, e.mc, e.row, e.col}) begin
                    errors++;
                    $display("FAIL random_data@%0d: got disp=%0d cost=%0d row=%0d col=%0d want disp=%0d cost=%0d row=%0d col=%0d",
                             k, disparity, min_cost, out_row, out_col, e.disp, e.mc, e.row, e.col);
                end
            end
        end
        set_pixel(1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        localparam int NPIX = 3 * W;
        exp_t e;
        int   pulses;
        int   r;
        pulses = 0;
        for (int k = 0; k < NPIX + 8; k++) begin
            if (k < NPIX) begin
                r = 198 + k / W;
                if (r >= H) r = r - H;
                random_lanes();
                set_pixel(1'b1, r, k % W);
            end else begin
                set_pixel(1'b0, 0, 0);
            end
            step(e);
            if (k >= 8) begin
                checks++;
                if (valid !== 1'b1) begin errors++; $display("FAIL b2b_valid@%0d: got %0b want 1", k, valid); end
            end
            if (frame_done === 1'b1) begin
                pulses++;
                checks++;
                if ({out_row, out_col} !== {10'(H - 1), 10'(W - 1)}) begin
                    errors++;
                    $display("FAIL b2b_done_pos: got row=%0d col=%0d want row=%0d col=%0d", out_row, out_col, H - 1, W - 1);
                end
            end
            checks++;
            if ({valid, frame_done, disparity, min_cost, out_row, out_col} !== {e.v, e.fd, e.disp, e.mc, e.row, e.col}) begin
                errors++;
                $display("FAIL b2b_data@%0d: got v=%0b fd=%0b disp=%0d cost=%0d want v=%0b fd=%0b disp=%0d cost=%0d",
                         k, valid, frame_done, disparity, min_cost, e.v, e.fd, e.disp, e.mc);
            end
        end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL b2b_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_midstream_reset();
        exp_t e;
        for (int d = 0; d < DR; d++) lanes[d] = (d == 5) ? 0 : 100;
        set_pixel(1'b1, H - 1, W - 1);
        step(e);
        set_pixel(1'b0, 0, 0);
        repeat (4) step(e);
        rst = 1'b1;
        #1;
        checks++;
        if ({valid, frame_done, disparity, min_cost, out_row, out_col} !== {1'b0, 1'b0, 8'd0, 8'hFF, 10'd0, 10'd0}) begin
            errors++;
            $display("FAIL midreset_outputs: got v=%0b fd=%0b disp=%0d cost=%0h row=%0d col=%0d want all reset values",
                     valid, frame_done, disparity, min_cost, out_row, out_col);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        for (int k = 0; k < 12; k++) begin
            step(e);
            checks++;
            if ({valid, frame_done} !== {e.v, e.fd}) begin
                errors++;
                $display("FAIL midreset_ghost@%0d: got valid=%0b fd=%0b want valid=%0b fd=%0b", k, valid, frame_done, e.v, e.fd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_midstream_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
